// File: rtl/sap1_pkg.sv
// Shared widths and bus-source encoding for the SAP-1 fetch path.
// Holds the source-priority helper used by the W-bus mux.
package sap1_pkg;

  localparam int PC_W_DEFAULT   = 4;
  localparam int BUS_W_DEFAULT  = 8;
  localparam int ADDR_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_PC   = 2'd1,
    SRC_EXT  = 2'd2
  } bus_src_e;

  // PC drive wins over the external source when both are enabled
  function automatic bus_src_e sel_src(input logic ep, input logic ext_en);
    bus_src_e src;
    if (ep) begin
      src = SRC_PC;
    end else if (ext_en) begin
      src = SRC_EXT;
    end else begin
      src = SRC_NONE;
    end
    return src;
  endfunction

endpackage

// File: rtl/sap1_pc.sv
// SAP-1 program counter: synchronous clear, optional parallel load, wrap-around count.
// Priority is clr > jmp_en > cnt_en; the count wraps silently at 2^PC_W.
module sap1_pc
  import sap1_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            cnt_en,
  input  logic            jmp_en,
  input  logic [PC_W-1:0] jmp_val,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_r;

  // counter register with clear, jump-load and increment
  always_ff @(posedge clk) begin
    if (clr) begin
      pc_r <= {PC_W{1'b0}};
    end else if (jmp_en) begin
      pc_r <= jmp_val;
    end else if (cnt_en) begin
      pc_r <= pc_r + {{(PC_W-1){1'b0}}, 1'b1};
    end else begin
      pc_r <= pc_r;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/sap1_fetch_path.sv
// SAP-1 fetch path: PC, combinational W-bus mux and MAR (active-low load).
// Optional PC jump input Jp is present only when SAP1_PC_JUMP_EN is defined.
module sap1_fetch_path
  import sap1_pkg::*;
#(
  parameter int PC_W   = PC_W_DEFAULT,
  parameter int BUS_W  = BUS_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              Cp,
  input  logic              Ep,
  input  logic              Lm,
`ifdef SAP1_PC_JUMP_EN
  input  logic              Jp,
`endif
  input  logic              ext_en,
  input  logic [BUS_W-1:0]  ext_in,
  output logic [PC_W-1:0]   pc_out,
  output logic [BUS_W-1:0]  bus_out,
  output logic [ADDR_W-1:0] mar_out,
  output logic              bus_conflict
);

  logic [PC_W-1:0]   pc_s;
  logic [BUS_W-1:0]  bus_s;
  logic [ADDR_W-1:0] mar_r;
  logic              jmp_en_s;
  bus_src_e          src_s;

`ifdef SAP1_PC_JUMP_EN
  assign jmp_en_s = Jp;
`else
  assign jmp_en_s = 1'b0;
`endif

  sap1_pc #(
    .PC_W (PC_W)
  ) u_pc (
    .clk     (CLK),
    .clr     (CLR),
    .cnt_en  (Cp),
    .jmp_en  (jmp_en_s),
    .jmp_val (bus_s[PC_W-1:0]),
    .pc      (pc_s)
  );

  // W-bus source selection, purely combinational
  always_comb begin
    src_s = sel_src(Ep, ext_en);
    bus_s = {BUS_W{1'b0}};
    case (src_s)
      SRC_PC:   bus_s = BUS_W'(pc_s);
      SRC_EXT:  bus_s = ext_in;
      SRC_NONE: bus_s = {BUS_W{1'b0}};
      default:  bus_s = {BUS_W{1'b0}};
    endcase
  end

  // MAR takes the low bus bits; sees the pre-increment PC during T1/T2 overlap
  always_ff @(posedge CLK) begin
    if (CLR) begin
      mar_r <= {ADDR_W{1'b0}};
    end else if (!Lm) begin
      mar_r <= bus_s[ADDR_W-1:0];
    end else begin
      mar_r <= mar_r;
    end
  end

  assign pc_out       = pc_s;
  assign bus_out      = bus_s;
  assign mar_out      = mar_r;
  assign bus_conflict = Ep & ext_en;

endmodule

// File: tb/tb_sap1_fetch_path.sv
// Self-checking bench for sap1_fetch_path: vector table plus wrap and jump sequences.
// Jump checks are compiled in only when SAP1_PC_JUMP_EN is defined.
module tb_sap1_fetch_path;

  logic       CLK = 1'b0;
  logic       CLR, Cp, Ep, Lm, ext_en;
  logic       Jp;
  logic [7:0] ext_in;
  logic [3:0] pc_out;
  logic [7:0] bus_out;
  logic [3:0] mar_out;
  logic       bus_conflict;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       clr;
    logic       cp;
    logic       ep;
    logic       lm;
    logic       ext_en;
    logic       jp;
    logic [7:0] ext_in;
    logic [3:0] pc;
    logic [3:0] mar;
    logic [7:0] bus;
    logic       conflict;
  } vec_t;

  vec_t sb_q[$];
  vec_t tbl[14];

  always #5 CLK = ~CLK;

  sap1_fetch_path #(.PC_W(4), .BUS_W(8), .ADDR_W(4)) dut (
    .CLK          (CLK),
    .CLR          (CLR),
    .Cp           (Cp),
    .Ep           (Ep),
    .Lm           (Lm),
`ifdef SAP1_PC_JUMP_EN
    .Jp           (Jp),
`endif
    .ext_en       (ext_en),
    .ext_in       (ext_in),
    .pc_out       (pc_out),
    .bus_out      (bus_out),
    .mar_out      (mar_out),
    .bus_conflict (bus_conflict)
  );

  function automatic vec_t mk(input logic clr, input logic cp, input logic ep, input logic lm,
                              input logic xen, input logic jp, input logic [7:0] xin,
                              input logic [3:0] pc, input logic [3:0] mar,
                              input logic [7:0] bus, input logic cfl);
    vec_t v;
    v.clr = clr; v.cp = cp; v.ep = ep; v.lm = lm; v.ext_en = xen; v.jp = jp;
    v.ext_in = xin; v.pc = pc; v.mar = mar; v.bus = bus; v.conflict = cfl;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, got, exp);
    end
  endtask

  // drive one vector, clock one edge, compare against the queued expectation
  task automatic step(input vec_t v, input int idx);
    vec_t e;
    CLR = v.clr; Cp = v.cp; Ep = v.ep; Lm = v.lm;
    ext_en = v.ext_en; ext_in = v.ext_in; Jp = v.jp;
    sb_q.push_back(v);
    @(posedge CLK);
    #1;
    e = sb_q.pop_front();
    check("pc_out",       idx, {4'h0, pc_out},       {4'h0, e.pc});
    check("mar_out",      idx, {4'h0, mar_out},      {4'h0, e.mar});
    check("bus_out",      idx, bus_out,              e.bus);
    check("bus_conflict", idx, {7'h00, bus_conflict}, {7'h00, e.conflict});
  endtask

  initial begin
    CLR = 1'b0; Cp = 1'b0; Ep = 1'b0; Lm = 1'b1;
    ext_en = 1'b0; ext_in = 8'h00; Jp = 1'b0;

    //             clr   cp    ep    lm    xen   jp    ext_in  pc     mar    bus    cfl
    tbl[0]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 8'h00, 1'b0);
    tbl[1]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'h1, 4'h0, 8'h01, 1'b0);
    tbl[2]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'h2, 4'h1, 8'h02, 1'b0);
    tbl[3]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'h3, 4'h2, 8'h03, 1'b0);
    tbl[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA7, 4'h3, 4'h7, 8'hA7, 1'b0);
    tbl[5]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA7, 4'h3, 4'h7, 8'h03, 1'b1);
    tbl[6]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'h3, 4'h7, 8'h00, 1'b0);
    tbl[7]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'h3, 4'h7, 8'h00, 1'b0);
    tbl[8]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'h3, 4'h7, 8'h00, 1'b0);
    tbl[9]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'h3, 4'h7, 8'h00, 1'b0);
    tbl[10] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'h3, 4'h7, 8'h00, 1'b0);
    tbl[11] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5B, 4'h4, 4'hB, 8'h5B, 1'b0);
    tbl[12] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3, 4'h5, 4'h0, 8'h00, 1'b0);
    tbl[13] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 4'h0, 4'h0, 8'h00, 1'b1);

    for (int i = 0; i < 14; i++) begin
      step(tbl[i], i);
    end

    // count up to 4'hF with MAR held, then wrap while MAR grabs the old PC
    for (int i = 0; i < 15; i++) begin
      step(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00,
              4'(i + 1), 4'h0, 8'(i + 1), 1'b0), 100 + i);
    end
    step(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 4'hF, 8'h00, 1'b0), 200);

`ifdef SAP1_PC_JUMP_EN
    step(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h0C, 4'hC, 4'hF, 8'h0C, 1'b0), 300);
    step(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'hD, 4'hF, 8'h0D, 1'b0), 301);
    step(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h09, 4'h0, 4'h0, 8'h09, 1'b0), 302);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
